// File: rtl/ammo_launcher.sv
// Single-projectile launcher: fire-edge launch from the ship, per-frame ascent, hit/top retire, cooldown, hit score.
// Optional magazine with timed reload is enabled by defining AMMO_MAG_EN.
module ammo_launcher #(
  parameter int unsigned AMMO_SIZE     = 4,
  parameter int unsigned AMMO_STEP     = 6,
  parameter int unsigned Y_TOP         = 3,
  parameter int unsigned PARK_X        = 700,
  parameter int unsigned COOLDOWN      = 8,
`ifdef AMMO_MAG_EN
  parameter int unsigned RELOAD_FRAMES = 60,
`endif
  parameter int unsigned MAG_SIZE      = 3
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       fire,
  input  logic [9:0] ship_x,
  input  logic [9:0] ship_y,
  input  logic       bullet_hit,
  output logic [9:0] ball_ammo_x,
  output logic [9:0] ball_ammo_y,
  output logic [9:0] ball_ammo_size,
  output logic       ammo_active,
  output logic [7:0] hit_count,
  output logic [2:0] ammo_left
);

  localparam int unsigned CW = $clog2(COOLDOWN + 1);

  localparam logic [9:0]    TOP_V   = 10'(Y_TOP);
  localparam logic [9:0]    LIMIT_V = 10'(Y_TOP + AMMO_STEP);
  localparam logic [9:0]    STEP_V  = 10'(AMMO_STEP);
  localparam logic [9:0]    PARK_V  = 10'(PARK_X);
  localparam logic [9:0]    SIZE_V  = 10'(AMMO_SIZE);
  localparam logic [2:0]    MAG_V   = 3'(MAG_SIZE);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLIGHT,
    S_COOL
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_fire_q;
  logic [9:0]    r_x, w_x_nxt;
  logic [9:0]    r_y, w_y_nxt;
  logic          r_active, w_active_nxt;
  logic [7:0]    r_hits, w_hits_nxt;
  logic [CW-1:0] r_cd, w_cd_nxt;
  logic          w_fire_edge;
  logic          w_launch_ok;

`ifdef AMMO_MAG_EN
  localparam int unsigned RW = $clog2(RELOAD_FRAMES + 1);
  localparam logic [RW-1:0] RL_LOAD = RW'(RELOAD_FRAMES - 1);

  logic [2:0]    r_ammo, w_ammo_nxt;
  logic [RW-1:0] r_reload, w_reload_nxt;
  logic          r_reloading, w_reloading_nxt;
  logic          w_retire;

  assign w_launch_ok = (r_ammo != '0);
  assign ammo_left   = r_ammo;
`else
  assign w_launch_ok = 1'b1;
  assign ammo_left   = MAG_V;
`endif

  assign w_fire_edge = fire & ~r_fire_q;

  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_active_nxt = r_active;
    w_hits_nxt   = r_hits;
    w_cd_nxt     = r_cd;
`ifdef AMMO_MAG_EN
    w_ammo_nxt      = r_ammo;
    w_reload_nxt    = r_reload;
    w_reloading_nxt = r_reloading;
    w_retire        = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_fire_edge && (ship_y >= TOP_V) && w_launch_ok) begin
          w_state_nxt  = S_FLIGHT;
          w_x_nxt      = ship_x;
          w_y_nxt      = ship_y;
          w_active_nxt = 1'b1;
`ifdef AMMO_MAG_EN
          w_ammo_nxt   = r_ammo - 3'd1;
`endif
        end
      end
      S_FLIGHT: begin
        // Hit outranks top-out; the compare also keeps the subtraction from wrapping.
        if (bullet_hit || (r_y < LIMIT_V)) begin
          if (bullet_hit) begin
            w_hits_nxt = (r_hits == 8'hFF) ? r_hits : r_hits + 8'd1;
          end
          w_state_nxt  = S_COOL;
          w_x_nxt      = PARK_V;
          w_y_nxt      = '0;
          w_active_nxt = 1'b0;
          w_cd_nxt     = CD_LOAD;
`ifdef AMMO_MAG_EN
          w_retire     = 1'b1;
`endif
        end else begin
          w_y_nxt = r_y - STEP_V;
        end
      end
      S_COOL: begin
        if (r_cd == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cd_nxt = r_cd - 1'b1;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_x_nxt      = PARK_V;
        w_y_nxt      = '0;
        w_active_nxt = 1'b0;
      end
    endcase
`ifdef AMMO_MAG_EN
    // Reload timer starts when the last round retires and runs alongside cooldown.
    if (r_reloading) begin
      if (r_reload == '0) begin
        w_ammo_nxt      = MAG_V;
        w_reloading_nxt = 1'b0;
      end else begin
        w_reload_nxt = r_reload - 1'b1;
      end
    end else if (w_retire && (r_ammo == '0)) begin
      w_reloading_nxt = 1'b1;
      w_reload_nxt    = RL_LOAD;
    end
`endif
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      r_state  <= S_IDLE;
      r_fire_q <= 1'b0;
      r_x      <= PARK_V;
      r_y      <= '0;
      r_active <= 1'b0;
      r_hits   <= '0;
      r_cd     <= '0;
`ifdef AMMO_MAG_EN
      r_ammo      <= MAG_V;
      r_reload    <= '0;
      r_reloading <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_fire_q <= fire;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_active <= w_active_nxt;
      r_hits   <= w_hits_nxt;
      r_cd     <= w_cd_nxt;
`ifdef AMMO_MAG_EN
      r_ammo      <= w_ammo_nxt;
      r_reload    <= w_reload_nxt;
      r_reloading <= w_reloading_nxt;
`endif
    end
  end

  assign ball_ammo_x    = r_x;
  assign ball_ammo_y    = r_y;
  assign ball_ammo_size = SIZE_V;
  assign ammo_active    = r_active;
  assign hit_count      = r_hits;

endmodule

// File: tb/tb_ammo_launcher.sv
// Directed self-checking bench for ammo_launcher; the magazine sequence runs when AMMO_MAG_EN is defined.
module tb_ammo_launcher;

  logic       frame_clk;
  logic       Reset_n;
  logic       fire;
  logic [9:0] ship_x;
  logic [9:0] ship_y;
  logic       bullet_hit;
  logic [9:0] ball_ammo_x;
  logic [9:0] ball_ammo_y;
  logic [9:0] ball_ammo_size;
  logic       ammo_active;
  logic [7:0] hit_count;
  logic [2:0] ammo_left;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_hits = 0;

  ammo_launcher dut (
    .frame_clk      (frame_clk),
    .Reset_n        (Reset_n),
    .fire           (fire),
    .ship_x         (ship_x),
    .ship_y         (ship_y),
    .bullet_hit     (bullet_hit),
    .ball_ammo_x    (ball_ammo_x),
    .ball_ammo_y    (ball_ammo_y),
    .ball_ammo_size (ball_ammo_size),
    .ammo_active    (ammo_active),
    .hit_count      (hit_count),
    .ammo_left      (ammo_left)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_parked(input string tag);
    chk({tag, "_active"}, 32'(ammo_active), 32'd0);
    chk({tag, "_x"}, 32'(ball_ammo_x), 32'd700);
    chk({tag, "_y"}, 32'(ball_ammo_y), 32'd0);
  endtask

  // Eight cooldown edges with fire toggling. late=0 puts an edge on the 8th
  // cooldown edge and idles one more; late=1 leaves the caller to launch on the 9th.
  task automatic cool(input bit late);
    for (int i = 0; i < 8; i++) begin
      fire = late ? ~i[0] : i[0];
      tick();
      chk("cool_active", 32'(ammo_active), 32'd0);
    end
    if (!late) begin
      fire = 1'b0;
      tick();
      chk("cool_idle", 32'(ammo_active), 32'd0);
    end
  endtask

  initial begin
    Reset_n = 1'b0; fire = 1'b1; ship_x = 10'd320; ship_y = 10'd400; bullet_hit = 1'b0;
    tick(); tick();
    chk_parked("rst");
    chk("rst_hits", 32'(hit_count), 32'd0);
    chk("rst_ammo", 32'(ammo_left), 32'd3);
    chk("size", 32'(ball_ammo_size), 32'd4);

`ifdef AMMO_MAG_EN
    Reset_n = 1'b1; fire = 1'b0; ship_x = 10'd200; ship_y = 10'd3;
    tick();
    for (int n = 0; n < 3; n++) begin
      fire = 1'b1; tick();
      chk("mag_launch", 32'(ammo_active), 32'd1);
      chk("mag_left", 32'(ammo_left), 32'(2 - n));
      fire = 1'b0; tick();
      chk("mag_retire", 32'(ammo_active), 32'd0);
      if (n < 2) begin
        for (int k = 0; k < 9; k++) tick();
      end
    end
    for (int k = 1; k <= 9; k++) tick();
    fire = 1'b1; tick();
    chk("mag_empty_blocked", 32'(ammo_active), 32'd0);
    chk("mag_empty_left", 32'(ammo_left), 32'd0);
    fire = 1'b0;
    for (int k = 11; k <= 59; k++) tick();
    chk("mag_before_reload", 32'(ammo_left), 32'd0);
    tick();
    chk("mag_reloaded", 32'(ammo_left), 32'd3);
    fire = 1'b1; tick();
    chk("mag_relaunch", 32'(ammo_active), 32'd1);
    chk("mag_relaunch_left", 32'(ammo_left), 32'd2);
`else
    // Fire held through reset gives a launch on the first active edge.
    Reset_n = 1'b1;
    tick();
    chk("t1_active", 32'(ammo_active), 32'd1);
    chk("t1_x", 32'(ball_ammo_x), 32'd320);
    chk("t1_y", 32'(ball_ammo_y), 32'd400);
    for (int i = 0; i < 5; i++) tick();
    chk("t2_y", 32'(ball_ammo_y), 32'd370);
    chk("t2_x", 32'(ball_ammo_x), 32'd320);
    chk("t2_still", 32'(ammo_active), 32'd1);
    bullet_hit = 1'b1; tick(); bullet_hit = 1'b0;
    chk_parked("t2_hit");
    chk("t2_hits", 32'(hit_count), 32'd1);
    cool(1'b0);

    fire = 1'b1; ship_x = 10'd100; ship_y = 10'd400; tick();
    chk("t3_x", 32'(ball_ammo_x), 32'd100);
    chk("t3_y", 32'(ball_ammo_y), 32'd400);
    fire = 1'b0; tick(); tick();
    chk("t3_y2", 32'(ball_ammo_y), 32'd388);
    bullet_hit = 1'b1; tick(); bullet_hit = 1'b0;
    chk_parked("t3_hit");
    chk("t3_hits", 32'(hit_count), 32'd2);
    cool(1'b1);

    fire = 1'b1; ship_x = 10'd50; ship_y = 10'd20; tick();
    chk("t4_launch", 32'(ammo_active), 32'd1);
    chk("t4_y20", 32'(ball_ammo_y), 32'd20);
    fire = 1'b0; tick();
    chk("t4_y14", 32'(ball_ammo_y), 32'd14);
    tick();
    chk("t4_y8", 32'(ball_ammo_y), 32'd8);
    tick();
    chk_parked("t4_top");
    chk("t4_hits", 32'(hit_count), 32'd2);
    cool(1'b0);

    fire = 1'b1; tick();
    fire = 1'b0; tick();
    chk("t4r_y14", 32'(ball_ammo_y), 32'd14);
    Reset_n = 1'b0; fire = 1'b1; tick();
    chk_parked("t4_rst");
    chk("t4_rst_hits", 32'(hit_count), 32'd0);
    Reset_n = 1'b1; tick();
    chk("t4_post_rst_launch", 32'(ammo_active), 32'd1);
    chk("t4_post_rst_y", 32'(ball_ammo_y), 32'd20);
    fire = 1'b0; tick(); tick(); tick();
    chk_parked("t4r_top");
    cool(1'b1);

    fire = 1'b1; ship_y = 10'd2; tick();
    chk("low_ship_ignored", 32'(ammo_active), 32'd0);
    fire = 1'b0; ship_y = 10'd3; tick();
    fire = 1'b1; tick();
    chk("edge_ship_launch", 32'(ammo_active), 32'd1);
    chk("edge_ship_y", 32'(ball_ammo_y), 32'd3);
    fire = 1'b0; tick();
    chk_parked("edge_ship_top");
    chk("edge_ship_hits", 32'(hit_count), 32'd0);
    cool(1'b1);

    fire = 1'b1; ship_x = 10'd512; ship_y = 10'd400; tick();
    chk("t5_launch", 32'(ammo_active), 32'd1);
    for (int i = 1; i < 40; i++) begin
      tick();
      chk("t5_hold_y", 32'(ball_ammo_y), 32'(400 - 6 * i));
    end
    fire = 1'b0;
    for (int i = 1; i <= 27; i++) begin
      tick();
      chk("t5_climb_y", 32'(ball_ammo_y), 32'(166 - 6 * i));
    end
    chk("t5_x_hold", 32'(ball_ammo_x), 32'd512);
    bullet_hit = 1'b1; tick(); bullet_hit = 1'b0;
    chk_parked("t5_hit_top");
    chk("t5_hits", 32'(hit_count), 32'd1);
    cool(1'b1);

    exp_hits = 1;
    for (int i = 0; i < 256; i++) begin
      fire = 1'b1; tick();
      chk("sat_launch", 32'(ammo_active), 32'd1);
      fire = 1'b0; bullet_hit = 1'b1; tick(); bullet_hit = 1'b0;
      exp_hits = (exp_hits < 255) ? exp_hits + 1 : 255;
      chk("sat_hits", 32'(hit_count), 32'(exp_hits));
      cool(1'b1);
    end
    chk("sat_final", 32'(hit_count), 32'd255);
    chk("ammo_const", 32'(ammo_left), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
